imem_sync_loadable: RTL

//  Parametrised instruction memory for the pipelined MIPS core, replacing the fixed combinational

---
 rtl/imem_sync_loadable_if.sv | 37 +++
 rtl/imem_sync_loadable.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/imem_sync_loadable_if.sv
// Bus bundle for the loadable instruction memory: boot-loader write port,
// IF-stage fetch port and the run/load status returned to the core.
interface imem_sync_loadable_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
);
    localparam int IDX_W = $clog2(DEPTH);

    // Loader side
    logic              load_mode;
    logic              ld_we;
    logic [31:0]       ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [IDX_W:0]    ld_count;

    // Fetch side
    logic              if_req;
    logic              if_stall;
    logic [31:0]       if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_misalign;
    logic              if_oob;
    logic              ready;

    // Core / boot loader drives requests and observes results
    modport master (
        output load_mode, ld_we, ld_addr, ld_data, if_req, if_stall, if_addr,
        input  ld_count, if_rdata, if_valid, if_misalign, if_oob, ready
    );

    // Memory answers requests
    modport slave (
        input  load_mode, ld_we, ld_addr, ld_data, if_req, if_stall, if_addr,
        output ld_count, if_rdata, if_valid, if_misalign, if_oob, ready
    );
endinterface

// File: rtl/imem_sync_loadable.sv
// Loadable instruction memory for the pipelined MIPS core.
// A boot loader fills the array while the block sits in LOAD; after one DRAIN
// cycle the block enters RUN and serves registered (1-cycle) fetches with
// stall hold. Illegal fetch addresses return NOP (all zeros) plus flags.
// The array has no reset so a program survives a reset pulse.
module imem_sync_loadable #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_sync_loadable_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_r;
    state_t            state_next_s;
    logic [IDX_W:0]    count_r;
    logic [IDX_W:0]    count_next_s;
    logic              ready_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] rdata_next_s;
    logic              valid_r;
    logic              valid_next_s;
    logic              mis_r;
    logic              mis_next_s;
    logic              oob_r;
    logic              oob_next_s;

    // Load-port decode
    logic [IDX_W-1:0]  ld_idx_s;
    logic              ld_ok_s;
    // Fetch-port decode
    logic [IDX_W-1:0]  fe_idx_s;
    logic              fe_mis_s;
    logic              fe_oob_s;
    logic [DATA_W-1:0] fe_word_s;

    assign ld_idx_s = bus.ld_addr[IDX_W+1:2];
    assign fe_idx_s = bus.if_addr[IDX_W+1:2];
    assign fe_mis_s = (bus.if_addr[1:0] != 2'b00);
    // Any byte-address bit above the index field, or an index past a
    // non-power-of-two DEPTH, is outside the array.
    assign fe_oob_s = (|bus.if_addr[31:IDX_W+2]) || ({1'b0, fe_idx_s} >= DEPTH_L);

    // Load write is legal only in LOAD, word aligned and inside the array
    always_comb begin
        ld_ok_s = 1'b0;
        if (state_r == ST_LOAD && bus.ld_we && bus.ld_addr[1:0] == 2'b00 &&
            !(|bus.ld_addr[31:IDX_W+2]) && ({1'b0, ld_idx_s} < DEPTH_L)) begin
            ld_ok_s = 1'b1;
        end else begin
            ld_ok_s = 1'b0;
        end
    end

    // Array read, gated so an illegal address never indexes past the array
    always_comb begin
        fe_word_s = '0;
        if (!fe_mis_s && !fe_oob_s) begin
            fe_word_s = mem[fe_idx_s];
        end else begin
            fe_word_s = '0;
        end
    end

    // Next-state logic for the LOAD / DRAIN / RUN sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD:  state_next_s = bus.load_mode ? ST_LOAD : ST_DRAIN;
            ST_DRAIN: state_next_s = bus.load_mode ? ST_LOAD : ST_RUN;
            ST_RUN:   state_next_s = bus.load_mode ? ST_LOAD : ST_RUN;
            default:  state_next_s = ST_LOAD;
        endcase
    end

    // Load counter: cleared on entry to LOAD, saturating count of accepted writes
    always_comb begin
        count_next_s = count_r;
        if (state_r != ST_LOAD && state_next_s == ST_LOAD) begin
            count_next_s = '0;
        end else if (ld_ok_s && count_r != {(IDX_W + 1){1'b1}}) begin
            count_next_s = count_r + {{IDX_W{1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Fetch output next values: zero outside steady RUN, hold on stall
    always_comb begin
        rdata_next_s = rdata_r;
        valid_next_s = valid_r;
        mis_next_s   = mis_r;
        oob_next_s   = oob_r;
        if (state_r != ST_RUN || state_next_s != ST_RUN) begin
            rdata_next_s = '0;
            valid_next_s = 1'b0;
            mis_next_s   = 1'b0;
            oob_next_s   = 1'b0;
        end else if (bus.if_stall) begin
            rdata_next_s = rdata_r;
            valid_next_s = valid_r;
            mis_next_s   = mis_r;
            oob_next_s   = oob_r;
        end else if (bus.if_req) begin
            rdata_next_s = fe_word_s;
            valid_next_s = 1'b1;
            mis_next_s   = fe_mis_s;
            oob_next_s   = fe_oob_s;
        end else begin
            rdata_next_s = '0;
            valid_next_s = 1'b0;
            mis_next_s   = 1'b0;
            oob_next_s   = 1'b0;
        end
    end

    // Control and fetch output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_LOAD;
            count_r <= '0;
            ready_r <= 1'b0;
            rdata_r <= '0;
            valid_r <= 1'b0;
            mis_r   <= 1'b0;
            oob_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            ready_r <= (state_next_s == ST_RUN);
            rdata_r <= rdata_next_s;
            valid_r <= valid_next_s;
            mis_r   <= mis_next_s;
            oob_r   <= oob_next_s;
        end
    end

    // Program array write; intentionally unreset so contents survive reset
    always_ff @(posedge clk) begin
        if (ld_ok_s) begin
            mem[ld_idx_s] <= bus.ld_data;
        end
    end

    assign bus.ld_count    = count_r;
    assign bus.ready       = ready_r;
    assign bus.if_rdata    = rdata_r;
    assign bus.if_valid    = valid_r;
    assign bus.if_misalign = mis_r;
    assign bus.if_oob      = oob_r;

endmodule
